// File: rtl/rgb_pwm_sequencer_pkg.sv
// Shared types for the RGB PWM sequencer: channel modes, config record,
// breathe-ramp direction states.
package rgb_pwm_pkg;

  localparam int MODE_W = 2;
  // Widest duty the config record can carry; channels use the low PWM_W bits.
  localparam int DUTY_W = 16;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e             mode;
    logic [DUTY_W-1:0] duty;
  } cfg_t;

  typedef enum logic [0:0] {
    RAMP_UP = 1'b0,
    RAMP_DN = 1'b1
  } ramp_dir_e;

endpackage

// File: rtl/rgb_pwm_sequencer_if.sv
// Config write port of the RGB PWM sequencer: single-cycle strobe plus
// target channel, mode and duty.
interface rgb_pwm_sequencer_if #(
  parameter int NUM_CH = 3,
  parameter int PWM_W  = 8
);
  import rgb_pwm_pkg::*;

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [MODE_W-1:0] cfg_mode;
  logic [PWM_W-1:0]  cfg_duty;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_duty);
  modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_duty);

endinterface

// File: rtl/rgb_pwm_channel.sv
// One LED channel: pending/active config, effective-duty mux, PWM compare
// and registered output. Optional square-law stage under RGB_PWM_GAMMA_EN
// (adds one clk of led latency).
module rgb_pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_we,
  input  mode_e            cfg_mode,
  input  logic [PWM_W-1:0] cfg_duty,
  input  logic             period_end,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             blink_phase,
  input  logic [PWM_W-1:0] ramp,
  output logic             led
);

  localparam int DW2 = PWM_W + DUTY_W;

  cfg_t             pend, act;
  logic [PWM_W-1:0] eff;

  // pending takes host writes at any time; active only changes on a period
  // boundary so a period never mixes two duties (a write on the boundary
  // cycle lands in pending and waits for the next boundary)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.mode <= MODE_OFF;
      pend.duty <= '0;
      act.mode  <= MODE_OFF;
      act.duty  <= '0;
    end else begin
      if (period_end) act <= pend;
      if (cfg_we) begin
        pend.mode <= cfg_mode;
        pend.duty <= DUTY_W'(cfg_duty);
      end
    end
  end

  // effective duty for the current period from mode and shared timebase
  always_comb begin
    eff = '0;
    case (act.mode)
      MODE_OFF:     eff = '0;
      MODE_STATIC:  eff = PWM_W'(act.duty);
      MODE_BLINK:   eff = blink_phase ? PWM_W'(act.duty) : '0;
      MODE_BREATHE: eff = PWM_W'((DW2'(ramp) * DW2'(act.duty)) >> PWM_W);
      default:      eff = '0;
    endcase
  end

`ifdef RGB_PWM_GAMMA_EN
  localparam int PW2 = 2 * PWM_W;

  logic [PWM_W-1:0] eff_g, cnt_d;

  // square-law brightness; the counter is delayed with it to stay aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eff_g <= '0;
      cnt_d <= '0;
    end else begin
      eff_g <= PWM_W'((PW2'(eff) * PW2'(eff)) >> PWM_W);
      cnt_d <= pwm_cnt;
    end
  end

  // PWM compare, forced low while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= 1'b0;
    else        led <= en && (cnt_d < eff_g);
  end
`else
  // PWM compare, forced low while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= 1'b0;
    else        led <= en && (pwm_cnt < eff);
  end
`endif

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// Multi-channel LED PWM sequencer. Shared timebase (prescaler, PWM counter,
// blink phase, breathe ramp) feeding NUM_CH rgb_pwm_channel instances.
// Optional feature macro: RGB_PWM_GAMMA_EN (square-law duty, +1 clk latency).
module rgb_pwm_sequencer
  import rgb_pwm_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int PWM_W      = 8,
  parameter int PRESC_DIV  = 8,
  parameter int BLINK_PER  = 256,
  parameter int BREATH_PER = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  rgb_pwm_sequencer_if.slave  cfg,
  output logic [NUM_CH-1:0]   led,
  output logic                period_tick
);

  localparam int CH_W = (NUM_CH > 1)     ? $clog2(NUM_CH)     : 1;
  localparam int PS_W = (PRESC_DIV > 1)  ? $clog2(PRESC_DIV)  : 1;
  localparam int BL_W = (BLINK_PER > 1)  ? $clog2(BLINK_PER)  : 1;
  localparam int BR_W = (BREATH_PER > 1) ? $clog2(BREATH_PER) : 1;
  localparam logic [PWM_W-1:0] PWM_MAX = '1;

  logic [PS_W-1:0]  presc;
  logic [PWM_W-1:0] pwm_cnt;
  logic [BL_W-1:0]  blink_cnt;
  logic [BR_W-1:0]  breath_cnt;
  logic [PWM_W-1:0] ramp;
  logic             blink_phase;
  logic             tick, period_end, ramp_step, ramp_inc, ramp_dec;
  ramp_dir_e        dir_q, dir_d;

  // en gates tick, so everything downstream freezes with it
  assign tick       = en && (presc == PS_W'(PRESC_DIV - 1));
  assign period_end = tick && (pwm_cnt == PWM_MAX);
  assign ramp_step  = period_end && (breath_cnt == BR_W'(BREATH_PER - 1));

  // prescaler and PWM counter; pwm_cnt wraps naturally at 2**PWM_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      pwm_cnt     <= '0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= period_end;
      if (en)   presc   <= tick ? '0 : presc + PS_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  // blink phase toggles every BLINK_PER periods, breathe divider per period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      breath_cnt  <= '0;
    end else if (period_end) begin
      if (blink_cnt == BL_W'(BLINK_PER - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BL_W'(1);
      end
      breath_cnt <= ramp_step ? '0 : breath_cnt + BR_W'(1);
    end
  end

  // ramp direction state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= RAMP_UP;
    else        dir_q <= dir_d;
  end

  // direction flips on reaching either end of the triangle
  always_comb begin
    dir_d = dir_q;
    if (ramp_step) begin
      case (dir_q)
        RAMP_UP: if (ramp == PWM_MAX) dir_d = RAMP_DN;
        RAMP_DN: if (ramp == '0)      dir_d = RAMP_UP;
        default: dir_d = RAMP_UP;
      endcase
    end
  end

  // step decode: the turning step already moves the other way (no hold)
  always_comb begin
    ramp_inc = 1'b0;
    ramp_dec = 1'b0;
    if (ramp_step) begin
      case (dir_q)
        RAMP_UP: if (ramp == PWM_MAX) ramp_dec = 1'b1; else ramp_inc = 1'b1;
        RAMP_DN: if (ramp == '0)      ramp_inc = 1'b1; else ramp_dec = 1'b1;
        default: ramp_inc = 1'b0;
      endcase
    end
  end

  // breathe ramp value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ramp <= '0;
    else if (ramp_inc) ramp <= ramp + PWM_W'(1);
    else if (ramp_dec) ramp <= ramp - PWM_W'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;
    // out-of-range cfg_ch matches no channel and is dropped
    assign ch_we = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

    rgb_pwm_channel #(.PWM_W(PWM_W)) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .cfg_we      (ch_we),
      .cfg_mode    (mode_e'(cfg.cfg_mode)),
      .cfg_duty    (cfg.cfg_duty),
      .period_end  (period_end),
      .pwm_cnt     (pwm_cnt),
      .blink_phase (blink_phase),
      .ramp        (ramp),
      .led         (led[i])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Self-checking bench for rgb_pwm_sequencer. A period-level reference model
// (enabled-tick count -> period index -> blink phase / triangle ramp) predicts
// led and period_tick every clock; per-period high counts are also checked.
module tb_rgb_pwm_sequencer;
  import rgb_pwm_pkg::*;

  localparam int NUM_CH = 3, PWM_W = 4, PRESC_DIV = 1, BLINK_PER = 2, BREATH_PER = 1;
  localparam int PER = 1 << PWM_W;
  localparam int CH_W = 2;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [NUM_CH-1:0] led;
  logic period_tick;

  rgb_pwm_sequencer_if #(.NUM_CH(NUM_CH), .PWM_W(PWM_W)) cfg_bus ();

  rgb_pwm_sequencer #(
    .NUM_CH(NUM_CH), .PWM_W(PWM_W), .PRESC_DIV(PRESC_DIV),
    .BLINK_PER(BLINK_PER), .BREATH_PER(BREATH_PER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg(cfg_bus.slave),
    .led(led), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model state
  int n;
  int pend_m[NUM_CH], pend_d[NUM_CH], act_m[NUM_CH], act_d[NUM_CH];
  int prev_pwm;
  int prev_effg[NUM_CH];
  logic [NUM_CH-1:0] exp_led;
  logic exp_pt;
  // trace mismatch bookkeeping
  int mis;
  time mis_t;
  logic [NUM_CH-1:0] mis_led, mis_exp;
  // per-period high counts of the DUT output
  int win_acc[NUM_CH], win_last[NUM_CH];
  int win_p, win_cnt;

  function automatic int tri_ramp(input int p);
    int t;
    t = (p / BREATH_PER) % (2 * (PER - 1));
    return (t <= PER - 1) ? t : 2 * (PER - 1) - t;
  endfunction

  function automatic int eff_of(input int m, input int d, input int p);
    case (m)
      0:       return 0;
      1:       return d;
      2:       return ((p / BLINK_PER) % 2 == 1) ? d : 0;
      default: return (tri_ramp(p) * d) / PER;
    endcase
  endfunction

  function automatic int gam(input int e);
`ifdef RGB_PWM_GAMMA_EN
    return (e * e) / PER;
`else
    return e;
`endif
  endfunction

  task automatic model_reset();
    n = 0; prev_pwm = 0; win_cnt = 0; win_p = 0;
    exp_led = '0; exp_pt = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      pend_m[i] = 0; pend_d[i] = 0; act_m[i] = 0; act_d[i] = 0;
      prev_effg[i] = 0; win_acc[i] = 0; win_last[i] = 0;
    end
  endtask

  task automatic model_edge(input logic e, input logic we, input int ch, input int md, input int dt);
    int pwm, p, eff;
    pwm = n % PER;
    p = n / PER;
    exp_pt = e && (pwm == PER - 1);
    for (int i = 0; i < NUM_CH; i++) begin
      eff = eff_of(act_m[i], act_d[i], p);
`ifdef RGB_PWM_GAMMA_EN
      exp_led[i] = e && (prev_pwm < prev_effg[i]);
      prev_effg[i] = gam(eff);
`else
      exp_led[i] = e && (pwm < eff);
`endif
    end
    prev_pwm = pwm;
    if (e && pwm == PER - 1)
      for (int i = 0; i < NUM_CH; i++) begin act_m[i] = pend_m[i]; act_d[i] = pend_d[i]; end
    if (we && ch >= 0 && ch < NUM_CH) begin pend_m[ch] = md; pend_d[ch] = dt; end
    if (e) n++;
  endtask

  // one clock: drive at negedge, model the posedge, sample 1 time unit later
  task automatic step(input logic e, input logic we, input int ch, input int md, input int dt);
    @(negedge clk);
    en = e;
    cfg_bus.cfg_we = we;
    cfg_bus.cfg_ch = CH_W'(ch);
    cfg_bus.cfg_mode = 2'(md);
    cfg_bus.cfg_duty = PWM_W'(dt);
    @(posedge clk);
    model_edge(e, we, ch, md, dt);
    #1;
    if (led !== exp_led || period_tick !== exp_pt) begin
      if (mis == 0) begin mis_t = $time; mis_led = led; mis_exp = exp_led; end
      mis++;
    end
    for (int i = 0; i < NUM_CH; i++) win_acc[i] += (led[i] === 1'b1) ? 1 : 0;
    if (period_tick === 1'b1) begin
      for (int i = 0; i < NUM_CH; i++) begin win_last[i] = win_acc[i]; win_acc[i] = 0; end
      win_p = n / PER - 1;
      win_cnt++;
    end
  endtask

  task automatic advance(input int k, output bit to);
    int target, cyc;
    target = win_cnt + k;
    cyc = 0;
    while (win_cnt < target && cyc < 40 * k) begin step(1'b1, 1'b0, 0, 0, 0); cyc++; end
    to = (win_cnt < target);
  endtask

  task automatic test_reset();
    int first;
    bit to;
    rst_n = 1'b0; en = 1'b0;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_ch = '0; cfg_bus.cfg_mode = '0; cfg_bus.cfg_duty = '0;
    model_reset(); mis = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (led !== '0 || period_tick !== 1'b0)
      begin errors++; $display("FAIL reset_state: led=%b tick=%b want 000/0", led, period_tick); end
    @(negedge clk) rst_n = 1'b1;
    // run with ch0 lit until a period_tick is showing, then reset asynchronously
    step(1'b1, 1'b1, 0, 1, 15);
    repeat (47) step(1'b1, 1'b0, 0, 0, 0);
    checks++;
    if (period_tick !== 1'b1) begin errors++; $display("FAIL pre_reset_tick: tick=%b want 1", period_tick); end
    #2 rst_n = 1'b0; en = 1'b0; cfg_bus.cfg_we = 1'b0;
    #1;
    checks++;
    if (period_tick !== 1'b0 || led !== '0)
      begin errors++; $display("FAIL async_clear_tick: led=%b tick=%b want 000/0", led, period_tick); end
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    first = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      step(1'b1, 1'b0, 0, 0, 0);
      if (period_tick === 1'b1) first = k;
    end
    checks++;
    if (first != 16) begin errors++; $display("FAIL first_tick: got at clk %0d want 16", first); end
    // mid-period reset while ch0 is high
    step(1'b1, 1'b1, 0, 1, 15);
    advance(2, to);
    repeat (5) step(1'b1, 1'b0, 0, 0, 0);
    checks++;
    if (to || led[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_led: led=%b want ch0 high", led); end
    #2 rst_n = 1'b0; en = 1'b0; cfg_bus.cfg_we = 1'b0;
    #1;
    checks++;
    if (led !== '0 || period_tick !== 1'b0)
      begin errors++; $display("FAIL async_clear_led: led=%b tick=%b want 000/0", led, period_tick); end
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) step(1'b1, 1'b0, 0, 0, 0);
    checks++;
    if (mis != 0)
      begin errors++; $display("FAIL reset_trace: %0d clk differ, first at %0t led=%b want %b", mis, mis_t, mis_led, mis_exp); end
    mis = 0;
  endtask

  task automatic test_static();
    int duties[6];
    bit to;
    duties = '{5, 0, 15, 8, 1, 0};
    duties[5] = $urandom_range(2, 14);
    foreach (duties[j]) begin
      step(1'b1, 1'b1, 0, 1, duties[j]);
      advance(2, to);
      checks++;
      if (to || win_last[0] != gam(duties[j]))
        begin errors++; $display("FAIL static_duty%0d: high=%0d want %0d", duties[j], win_last[0], gam(duties[j])); end
    end
    checks++;
    if (mis != 0)
      begin errors++; $display("FAIL static_trace: %0d clk differ, first at %0t led=%b want %b", mis, mis_t, mis_led, mis_exp); end
    mis = 0;
  endtask

  task automatic test_boundary();
    bit to;
    step(1'b1, 1'b1, 0, 0, 0);
    step(1'b1, 1'b1, 1, 1, 15);
    advance(2, to);
    for (int k = 0; k < 20 && (n % PER) != PER - 1; k++) step(1'b1, 1'b0, 0, 0, 0);
    // write lands on the period_end clock
    step(1'b1, 1'b1, 1, 1, 3);
    checks++;
    if (period_tick !== 1'b1) begin errors++; $display("FAIL bnd_align: tick=%b want 1", period_tick); end
    advance(1, to);
    checks++;
    if (to || win_last[1] != gam(15))
      begin errors++; $display("FAIL bnd_old: high=%0d want %0d", win_last[1], gam(15)); end
    repeat (8) step(1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 1, 1, 9);
    advance(1, to);
    checks++;
    if (to || win_last[1] != gam(3))
      begin errors++; $display("FAIL bnd_new3: high=%0d want %0d", win_last[1], gam(3)); end
    advance(1, to);
    checks++;
    if (to || win_last[1] != gam(9))
      begin errors++; $display("FAIL bnd_new9: high=%0d want %0d", win_last[1], gam(9)); end
    checks++;
    if (mis != 0)
      begin errors++; $display("FAIL bnd_trace: %0d clk differ, first at %0t led=%b want %b", mis, mis_t, mis_led, mis_exp); end
    mis = 0;
  endtask

  task automatic test_blink();
    bit to;
    int on_cnt, want;
    step(1'b1, 1'b1, 1, 0, 0);
    step(1'b1, 1'b1, 2, 2, 8);
    advance(2, to);
    on_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      advance(1, to);
      want = ((win_p / BLINK_PER) % 2 == 1) ? gam(8) : 0;
      if (win_last[2] != 0) on_cnt++;
      checks++;
      if (to || win_last[2] != want || win_last[0] != 0)
        begin errors++; $display("FAIL blink_p%0d: high=%0d want %0d", win_p, win_last[2], want); end
    end
    checks++;
    if (on_cnt != 4) begin errors++; $display("FAIL blink_ratio: on periods=%0d want 4", on_cnt); end
    checks++;
    if (mis != 0)
      begin errors++; $display("FAIL blink_trace: %0d clk differ, first at %0t led=%b want %b", mis, mis_t, mis_led, mis_exp); end
    mis = 0;
  endtask

  task automatic test_breathe();
    bit to;
    int want;
    step(1'b1, 1'b1, 2, 0, 0);
    step(1'b1, 1'b1, 0, 3, 15);
    advance(2, to);
    for (int k = 0; k < 34; k++) begin
      advance(1, to);
      want = gam((tri_ramp(win_p) * 15) / PER);
      checks++;
      if (to || win_last[0] != want)
        begin errors++; $display("FAIL breathe_p%0d: high=%0d want %0d", win_p, win_last[0], want); end
    end
    repeat (5) step(1'b1, 1'b0, 0, 0, 0);
    // freeze mid-period; an out-of-range channel write must have no effect
    for (int k = 0; k < 10; k++) begin
      step(1'b0, k == 4, 3, 1, 15);
      checks++;
      if (led !== '0 || period_tick !== 1'b0)
        begin errors++; $display("FAIL freeze_%0d: led=%b tick=%b want 000/0", k, led, period_tick); end
    end
    advance(3, to);
    checks++;
    if (to || mis != 0)
      begin errors++; $display("FAIL breathe_trace: %0d clk differ, first at %0t led=%b want %b", mis, mis_t, mis_led, mis_exp); end
    mis = 0;
  endtask

  task automatic test_random();
    logic e, we;
    for (int k = 0; k < 400; k++) begin
      e = ($urandom_range(0, 9) != 0);
      we = ($urandom_range(0, 4) == 0);
      step(e, we, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
    end
    checks++;
    if (mis != 0)
      begin errors++; $display("FAIL random_trace: %0d clk differ, first at %0t led=%b want %b", mis, mis_t, mis_led, mis_exp); end
    mis = 0;
  endtask

  initial begin
    test_reset();
    test_static();
    test_boundary();
    test_blink();
    test_breathe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
